// File: rtl/mux_scan_force_if.sv
// mux_scan_force_if: request/response bundle for mux_scan_force.
//   master: drives en, mode, sel, force_s, force_a, in_data, out_ready;
//           observes out_valid, out_data, out_chan, out_forced, out_err, out_seq.
//   slave : the mux side of the same signals.
interface mux_scan_force_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
);
   logic                      en;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic                      force_s;
   logic                      force_a;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic                      out_ready;
   logic                      out_valid;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_chan;
   logic                      out_forced;
   logic                      out_err;
   logic [7:0]                out_seq;

   modport master (
      output en, mode, sel, force_s, force_a, in_data, out_ready,
      input  out_valid, out_data, out_chan, out_forced, out_err, out_seq
   );

   modport slave (
      input  en, mode, sel, force_s, force_a, in_data, out_ready,
      output out_valid, out_data, out_chan, out_forced, out_err, out_seq
   );
endinterface

// File: rtl/mux_scan_force.sv
// mux_scan_force: registered CHANNELS-to-1 word mux with manual or round-robin
// scan select, a two-input force-to-FORCE_VAL override and a valid/ready
// output register.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of mux_scan_force_if (inputs, select, force,
//              backpressure and the registered output sample)

// One channel lane: passes its word only when it is the chosen channel, so the
// lane outputs can simply be OR-reduced.
module mux_scan_force_lane #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 2,
   parameter int IDX   = 0
) (
   input  logic [SEL_W-1:0] ch,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   assign dout = (ch == SEL_W'(IDX)) ? din : '0;
endmodule

module mux_scan_force #(
   parameter int               WIDTH     = 16,
   parameter int               CHANNELS  = 4,
   parameter int               SEL_W     = 2,
   parameter logic [WIDTH-1:0] FORCE_VAL = {WIDTH{1'b1}}
) (
   input logic            clk,
   input logic            rst,
   mux_scan_force_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] chan;
      logic             forced;
      logic             err;
   } resp_t;

   state_t                           state;
   logic [SEL_W-1:0]                 ptr;
   logic                             mode_q;
   logic                             started;
   logic                             valid_q;
   logic [7:0]                       seq_q;
   resp_t                            resp_q;

   logic                             mode_rise;
   logic [SEL_W-1:0]                 ptr_eff;
   logic [SEL_W-1:0]                 ch;
   logic                             cap;
   logic                             sel_bad;
   logic [CHANNELS-1:0][WIDTH-1:0]   lane_out;
   logic [WIDTH-1:0]                 sel_word;
   resp_t                            resp_d;

   // A fresh entry into scan mode starts from channel 0 on that very edge.
   assign mode_rise = bus.mode & ~mode_q;
   assign ptr_eff   = mode_rise ? '0 : ptr;
   assign ch        = bus.mode ? ptr_eff : bus.sel;
   // Capture whenever the output register is empty or being drained this edge.
   assign cap       = bus.en & (~valid_q | bus.out_ready);
   assign sel_bad   = ~bus.mode & ({{(32-SEL_W){1'b0}}, bus.sel} >= 32'(CHANNELS));

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      mux_scan_force_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(k)) u_lane (
         .ch   (ch),
         .din  (bus.in_data[k*WIDTH +: WIDTH]),
         .dout (lane_out[k])
      );
   end

   always_comb begin
      sel_word = '0;
      for (int k = 0; k < CHANNELS; k++) sel_word = sel_word | lane_out[k];
   end

   // Force wins over the bad-select error; the channel index is always reported.
   always_comb begin
      resp_d.chan   = ch;
      resp_d.forced = 1'b0;
      resp_d.err    = 1'b0;
      resp_d.data   = sel_word;
      if (bus.force_s && bus.force_a) begin
         resp_d.data   = FORCE_VAL;
         resp_d.forced = 1'b1;
      end else if (sel_bad) begin
         resp_d.data = '0;
         resp_d.err  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         mode_q  <= 1'b0;
         started <= 1'b0;
         valid_q <= 1'b0;
         seq_q   <= '0;
         resp_q  <= '0;
      end else begin
         mode_q <= bus.mode;
         if (mode_rise) ptr <= '0;
         if (cap) begin
            // Every state captures on cap: IDLE (empty), RUN, DRAIN (being read).
            state   <= RUN;
            valid_q <= 1'b1;
            resp_q  <= resp_d;
            seq_q   <= started ? seq_q + 8'd1 : 8'd0;
            started <= 1'b1;
            if (bus.mode)
               ptr <= (ptr_eff == SEL_W'(CHANNELS-1)) ? '0 : ptr_eff + SEL_W'(1);
         end else begin
            case (state)
               RUN: begin
                  if (!bus.en) begin
                     if (valid_q && !bus.out_ready) begin
                        state <= DRAIN;
                     end else begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                     end
                  end
               end
               DRAIN: begin
                  if (bus.out_ready) begin
                     state   <= IDLE;
                     valid_q <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.out_data   = resp_q.data;
   assign bus.out_chan   = resp_q.chan;
   assign bus.out_forced = resp_q.forced;
   assign bus.out_err    = resp_q.err;
   assign bus.out_seq    = seq_q;
endmodule

// File: tb/tb_mux_scan_force.sv
// tb_mux_scan_force: two builds (16x4 and 8x3) driven side by side; each cycle
// both are compared against a sample-level reference model, plus a vector table
// and hand sequences for stalls, drain, reset and the narrow build.
module tb_mux_scan_force;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mux_scan_force_if #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) b0 ();
   mux_scan_force_if #(.WIDTH(8),  .CHANNELS(3), .SEL_W(2)) b1 ();

   mux_scan_force #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
   mux_scan_force #(.WIDTH(8),  .CHANNELS(3), .SEL_W(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

   typedef struct packed {
      logic        valid;
      logic [15:0] data;
      logic [3:0]  chan;
      logic        forced;
      logic        err;
      logic [7:0]  seq;
      logic        started;
      logic [3:0]  ptr;
      logic        mode_q;
   } ms_t;

   ms_t m0, m1;

   // One clock edge of the output register seen as a sample buffer.
   function automatic ms_t mstep(ms_t s, logic r, logic en, logic mode, logic [3:0] sel,
                                 logic fs, logic fa, logic rdy, logic [63:0] din,
                                 int nch, int w);
      ms_t n;
      int  p, ch;
      logic [63:0] mask;
      n = s;
      if (r) return '0;
      mask = (64'd1 << w) - 64'd1;
      p = (mode && !s.mode_q) ? 0 : int'(s.ptr);
      n.mode_q = mode;
      if (mode && !s.mode_q) n.ptr = 0;
      if (en && (!s.valid || rdy)) begin
         ch = mode ? p : int'(sel);
         n.valid = 1'b1;
         n.chan = 4'(ch);
         n.forced = 1'b0;
         n.err = 1'b0;
         if (fs && fa) begin
            n.data = 16'(mask);
            n.forced = 1'b1;
         end else if (!mode && int'(sel) >= nch) begin
            n.data = 16'h0;
            n.err = 1'b1;
         end else begin
            n.data = 16'((din >> (ch * w)) & mask);
         end
         n.seq = s.started ? s.seq + 8'd1 : 8'd0;
         n.started = 1'b1;
         if (mode) n.ptr = 4'((p + 1) % nch);
      end else if (s.valid && rdy) begin
         n.valid = 1'b0;
      end
      return n;
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m0 = mstep(m0, rst, b0.en, b0.mode, 4'(b0.sel), b0.force_s, b0.force_a,
                 b0.out_ready, 64'(b0.in_data), 4, 16);
      m1 = mstep(m1, rst, b1.en, b1.mode, 4'(b1.sel), b1.force_s, b1.force_a,
                 b1.out_ready, 64'(b1.in_data), 3, 8);
      #1;
      chk("model0_valid", 64'(b0.out_valid), 64'(m0.valid));
      if (m0.valid)
         chk("model0_word", 64'({b0.out_data, b0.out_chan, b0.out_forced, b0.out_err, b0.out_seq}),
             64'({m0.data, m0.chan[1:0], m0.forced, m0.err, m0.seq}));
      chk("model1_valid", 64'(b1.out_valid), 64'(m1.valid));
      if (m1.valid)
         chk("model1_word", 64'({b1.out_data, b1.out_chan, b1.out_forced, b1.out_err, b1.out_seq}),
             64'({m1.data[7:0], m1.chan[1:0], m1.forced, m1.err, m1.seq}));
   endtask

   task automatic set0(logic en, logic mode, logic [1:0] sel, logic fs, logic fa, logic rdy);
      b0.en = en; b0.mode = mode; b0.sel = sel; b0.force_s = fs; b0.force_a = fa; b0.out_ready = rdy;
   endtask

   task automatic set1(logic en, logic mode, logic [1:0] sel, logic fs, logic fa, logic rdy);
      b1.en = en; b1.mode = mode; b1.sel = sel; b1.force_s = fs; b1.force_a = fa; b1.out_ready = rdy;
   endtask

   task automatic exp0(string nm, logic v, logic [15:0] d, logic [1:0] c, logic f, logic e, logic [7:0] s);
      chk(nm, 64'({b0.out_valid, b0.out_data, b0.out_chan, b0.out_forced, b0.out_err, b0.out_seq}),
          64'({v, d, c, f, e, s}));
   endtask

   task automatic exp1(string nm, logic [7:0] d, logic [1:0] c, logic f, logic e, logic [7:0] s);
      chk(nm, 64'({b1.out_valid, b1.out_data, b1.out_chan, b1.out_forced, b1.out_err, b1.out_seq}),
          64'({1'b1, d, c, f, e, s}));
   endtask

   typedef struct {
      logic        en, mode;
      logic [1:0]  sel;
      logic        fs, fa, rdy;
      logic        ev;
      logic [15:0] ed;
      logic [1:0]  ec;
      logic        ef;
      logic [7:0]  es;
   } vec_t;

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1, 0, 2, 0, 0, 1, 1, 16'h3333, 2, 0, 0};
      tbl[1]  = '{1, 0, 2, 0, 0, 1, 1, 16'h3333, 2, 0, 1};
      tbl[2]  = '{1, 0, 1, 1, 1, 1, 1, 16'hFFFF, 1, 1, 2};
      tbl[3]  = '{1, 0, 1, 1, 0, 1, 1, 16'h2222, 1, 0, 3};
      tbl[4]  = '{1, 0, 0, 0, 1, 1, 1, 16'h1111, 0, 0, 4};
      tbl[5]  = '{1, 1, 0, 0, 0, 1, 1, 16'h1111, 0, 0, 5};
      tbl[6]  = '{1, 1, 0, 0, 0, 1, 1, 16'h2222, 1, 0, 6};
      tbl[7]  = '{1, 1, 0, 0, 0, 1, 1, 16'h3333, 2, 0, 7};
      tbl[8]  = '{1, 1, 0, 0, 0, 1, 1, 16'h4444, 3, 0, 8};
      tbl[9]  = '{1, 1, 0, 0, 0, 1, 1, 16'h1111, 0, 0, 9};
      tbl[10] = '{1, 1, 0, 0, 0, 1, 1, 16'h2222, 1, 0, 10};
      tbl[11] = '{1, 1, 3, 1, 1, 1, 1, 16'hFFFF, 2, 1, 11};
      tbl[12] = '{0, 1, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0};

      m0 = '0; m1 = '0;
      rst = 1'b1;
      set0(0, 0, 0, 0, 0, 0);
      set1(0, 0, 0, 0, 0, 0);
      b0.in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      b1.in_data = {8'h33, 8'h22, 8'h11};
      tick(); tick();
      exp0("reset_state", 0, 16'h0, 0, 0, 0, 8'h0);
      chk("reset_err", 64'(b0.out_err), 64'(0));
      rst = 1'b0;

      // table: manual select, force qualifiers, scan wrap
      for (int i = 0; i < 13; i++) begin
         set0(tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].fs, tbl[i].fa, tbl[i].rdy);
         tick();
         chk($sformatf("tbl%0d_valid", i), 64'(b0.out_valid), 64'(tbl[i].ev));
         if (tbl[i].ev)
            exp0($sformatf("tbl%0d", i), 1, tbl[i].ed, tbl[i].ec, tbl[i].ef, 0, tbl[i].es);
      end

      // stall in scan mode: frozen outputs, no skipped channel, contiguous seq
      set0(1, 1, 0, 0, 0, 1); tick();
      exp0("stall_pre", 1, 16'h4444, 3, 0, 0, 8'd12);
      set0(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         exp0($sformatf("stall_hold%0d", i), 1, 16'h4444, 3, 0, 0, 8'd12);
      end
      set0(1, 1, 0, 0, 0, 1); tick();
      exp0("stall_post0", 1, 16'h1111, 0, 0, 0, 8'd13);
      tick();
      exp0("stall_post1", 1, 16'h2222, 1, 0, 0, 8'd14);

      // drain, then reset during drain
      set0(0, 1, 0, 0, 0, 0); tick();
      exp0("drain_hold0", 1, 16'h2222, 1, 0, 0, 8'd14);
      tick();
      exp0("drain_hold1", 1, 16'h2222, 1, 0, 0, 8'd14);
      set0(1, 1, 0, 0, 0, 1);
      rst = 1'b1; tick();
      exp0("drain_rst", 0, 16'h0, 0, 0, 0, 8'd0);
      chk("drain_rst_err", 64'(b0.out_err), 64'(0));
      rst = 1'b0;
      set0(0, 1, 0, 0, 0, 1); tick();
      chk("idle_after_rst", 64'(b0.out_valid), 64'(0));
      set0(1, 1, 0, 0, 0, 1); tick();
      exp0("ptr_cleared", 1, 16'h1111, 0, 0, 0, 8'd0);
      set0(0, 0, 0, 0, 0, 1); tick();

      // narrow build: bad select, force over err, scan wrap 2 -> 0
      set1(1, 0, 3, 0, 0, 1); tick();
      exp1("n_err", 8'h00, 3, 0, 1, 8'd0);
      set1(1, 0, 3, 1, 1, 1); tick();
      exp1("n_force_err", 8'hFF, 3, 1, 0, 8'd1);
      set1(1, 1, 0, 0, 0, 1); tick();
      exp1("n_scan0", 8'h11, 0, 0, 0, 8'd2);
      tick(); exp1("n_scan1", 8'h22, 1, 0, 0, 8'd3);
      tick(); exp1("n_scan2", 8'h33, 2, 0, 0, 8'd4);
      tick(); exp1("n_wrap", 8'h11, 0, 0, 0, 8'd5);

      // random phase against the model
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         b0.en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) b0.mode = ~b0.mode;
         b0.sel = 2'($urandom);
         b0.force_s = 1'($urandom); b0.force_a = 1'($urandom);
         b0.out_ready = 1'($urandom);
         b0.in_data = {$urandom, $urandom};
         b1.en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) b1.mode = ~b1.mode;
         b1.sel = 2'($urandom);
         b1.force_s = 1'($urandom); b1.force_a = 1'($urandom);
         b1.out_ready = 1'($urandom);
         b1.in_data = 24'($urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mux_scan_force.md
Name: mux_scan_force

Overview:
- Parametrised, registered successor to the 16-bit force-to-ones mux.
- Selects one of CHANNELS data words, either from a manual select or a round-robin scan pointer.
- Overrides the selected word with FORCE_VAL when both force inputs are high.
- Presents the result through a valid/ready output register, so a downstream consumer can apply backpressure without losing samples.

Parameters:
- WIDTH, 16: bits per channel word.
- CHANNELS, 4: number of input channels, 2 to 16.
- SEL_W, 2: select/pointer width; must satisfy 2^SEL_W >= CHANNELS.
- FORCE_VAL, {WIDTH{1'b1}}: word emitted while force is active.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: capture enable.
- mode, input, 1: 0 = manual (use sel), 1 = scan (use internal pointer).
- sel, input, SEL_W: manual channel select.
- force_s, input, 1: force qualifier s.
- force_a, input, 1: force qualifier a.
- in_data, input, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- out_ready, input, 1: downstream accepts the word when out_valid && out_ready.
- out_valid, output, 1: out_data is a captured sample.
- out_data, output, WIDTH: captured word.
- out_chan, output, SEL_W: channel index the word came from.
- out_forced, output, 1: word is FORCE_VAL due to the override.
- out_err, output, 1: manual sel was >= CHANNELS; out_data is 0.
- out_seq, output, 8: capture sequence number, wraps 255 -> 0.

Behaviour:
- Reset, synchronous, rst=1 at the edge:
  - out_valid=0, out_data=0, out_chan=0, out_forced=0, out_err=0, out_seq=0.
  - Scan pointer = 0; state = IDLE.
  - rst overrides every other input on the same edge, including a capture in progress.
- Capture condition: cap = en && (!out_valid || out_ready). On an edge with cap=1:
  - The output registers load.
  - out_valid=1 from the next cycle, so latency from input to output is 1 cycle.
- Channel choice:
  - ch = mode ? ptr : sel.
- Data loaded on capture:
  - Force active (force_s && force_a): out_data=FORCE_VAL, out_forced=1, out_err=0. Force takes priority over err.
  - Else, mode=0 and sel >= CHANNELS: out_data=0, out_err=1, out_forced=0.
  - Else: out_data=in_data[ch], out_forced=0, out_err=0.
  - out_chan=ch in all cases, including forced and err captures.
  - out_seq increments by 1 on every capture; it does not increment at the first capture after reset, which loads seq 0.
- Scan pointer:
  - Advances only on a capture edge with mode=1.
  - Wraps from CHANNELS-1 to 0.
  - Resets to 0 on rst, and on the edge where mode is sampled 1 after having been 0 (mode rising). That edge captures channel 0 and sets ptr=1.
  - In manual mode ptr holds.
- States:
  - IDLE: out_valid=0. Go to RUN on en=1; that edge is also the first capture.
  - RUN: capture per the rule above.
    - en=0 with out_valid=1 and out_ready=0: go to DRAIN and keep data stable.
    - en=0 with out_ready=1 or out_valid=0: out_valid goes to 0 and the state returns to IDLE.
  - DRAIN: hold all outputs. When out_ready=1, out_valid goes to 0 next cycle and the state returns to IDLE. If en returns to 1 while out_ready=1, capture and go to RUN instead.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data, out_chan, out_forced, out_err and out_seq are stable.
  - The pointer does not move and no sample is dropped or duplicated.
- Simultaneous accept and capture (out_valid=1, out_ready=1, en=1): the new word replaces the old in the same edge, giving full throughput of one word per cycle.
- Input changes between captures have no effect on the outputs.

Test Plan:
- Reset, then en=1, mode=0, sel=2, in_data channels = 16'h1111, 16'h2222, 16'h3333, 16'h4444, out_ready=1 -> one cycle later out_valid=1, out_data=16'h3333, out_chan=2, out_seq=0; out_seq increments each cycle thereafter.
- mode=1, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1 with the matching words (wrap-around check).
- Scan running, out_ready=0 for 3 cycles, then 1 -> outputs frozen during the stall, pointer not advanced, no channel skipped, seq contiguous.
- force_s=1 and force_a=1 during a capture -> out_data=16'hFFFF, out_forced=1, out_chan still the real channel. With only one of force_s/force_a high -> normal data, out_forced=0.
- Parameter build WIDTH=8, CHANNELS=3, mode=0, sel=3 -> out_data=8'h00, out_err=1. Scan mode on the same build -> wrap 2 -> 0.
- rst=1 asserted while in DRAIN with out_valid=1 -> next cycle all outputs 0, state IDLE, ptr=0.
